stack_pointer_unit: RTL and testbench
=====================================

// Module: stack_pointer_unit
// PURPOSE
//  Holds the main-stack (MS) and return-stack (RS) pointers of the JALA stack CPU.
//  Sits directly downstream of the multicycle control FSM and consumes its MSPop/MSPWrite
//  and RSPop/RSPWrite strobes. Drives stack-top addresses to the memory address muxes.
//  Detects overflow/underflow and freezes both stacks in a FAULT state until cleared.
// PARAMETERS
//  ADDR_W     16      memory address width
//  WORD_BYTES 2       byte stride per stack slot
//  MS_BASE    16'hFFFE  MS empty pointer (one past bottom slot); MS grows downward
//  MS_DEPTH   64      MS capacity in slots
//  RS_BASE    16'hFEFE  RS empty pointer; RS grows downward
//  RS_DEPTH   32      RS capacity in slots
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       synchronous reset, active low
//  MSPop       in   1       1 = pop, 0 = push; qualified by MSPWrite
//  MSPWrite    in   1       MS pointer update strobe
//  RSPop       in   1       1 = pop, 0 = push; qualified by RSPWrite
//  RSPWrite    in   1       RS pointer update strobe
//  err_clr     in   1       leave FAULT; pointers keep their values
//  ms_top      out  ADDR_W  address of MS top slot (= ms_sp)
//  ms_second   out  ADDR_W  address of MS second slot (= ms_sp + WORD_BYTES)
//  rs_top      out  ADDR_W  address of RS top slot (= rs_sp)
//  ms_depth    out  $clog2(MS_DEPTH+1)  occupied MS slots
//  rs_depth    out  $clog2(RS_DEPTH+1)  occupied RS slots
//  ms_empty, ms_full, rs_empty, rs_full  out 1  combinational from depth
//  fault       out  1       high while in FAULT
//  fault_code  out  3       [0] overflow, [1] underflow, [2] 0=MS/1=RS; 000 when no fault
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous, active low: on a rising edge of clk with
//    rst==0: ms_sp=MS_BASE, rs_sp=RS_BASE, depths=0, state=RUN, fault=0, fault_code=000.
//    Reset overrides every other input, including mid-FAULT and simultaneous strobes.
//  - FSM, 2 states. RUN: strobes are honoured. FAULT: all strobes are ignored and
//    pointers hold. FAULT->RUN only on err_clr==1; fault_code returns to 000 on the same edge.
//  - Updates are registered. A strobe at edge N changes the pointers, depths and flags
//    visible after edge N. No combinational path from the strobe inputs to the outputs.
//  - Push (xPWrite=1, xPop=0), not full: sp -= WORD_BYTES, depth += 1.
//  - Pop  (xPWrite=1, xPop=1), not empty: sp += WORD_BYTES, depth -= 1.
//  - Push when full: overflow. Pop when empty: underflow. On either, that stack holds,
//    state -> FAULT, fault_code is latched.
//  - MS and RS are independent. Both may update on the same edge.
//  - Same-edge faults: if MS and RS both fault, MS is recorded in fault_code. If only one
//    faults, the other stack's legal update on that edge still completes.
//  - err_clr in RUN: no effect. err_clr together with strobes in FAULT: clear only, the
//    strobes are dropped.
//  - Address arithmetic is modulo 2^ADDR_W. ms_second wraps silently when MS is empty;
//    its value is don't-care while empty.
//  - The full flag is depth==DEPTH, so the wrap-around of depth never occurs.
// STRUCTURE
//  - Package jala_pkg: WORD_BYTES constant, FAULT_* code localparams, sp_state_t {RUN, FAULT}.
//  - Sub-module stack_ptr_core (params BASE, DEPTH, ADDR_W):
//    sp/depth registers, empty/full, ovf/udf pulses, and a hold input driven by the
//    top-level FSM. Instantiated twice (MS, RS).
//  - Top level: FAULT FSM, fault priority encoding, and the ms_second adder.
// TESTING
//  1. Reset: rst=0 for 1 edge -> ms_top=FFFE, rs_top=FEFE, depths=0, ms_empty=rs_empty=1,
//     fault=0.
//  2. Three MS pushes, then one pop -> ms_top=FFF8 then FFFA, ms_second=FFFC, ms_depth=2.
//  3. Pop on empty RS -> fault=1, fault_code=110, rs_top stays FEFE. A following MS push
//     is ignored. err_clr -> fault=0, code=000.
//  4. 64 MS pushes -> ms_full=1, ms_top=FF7E. 65th push -> fault_code=001, ms_depth
//     stays 64.
//  5. Same-edge MS push and RS push -> both pointers move by -2. Same-edge MS underflow
//     and RS legal push -> code=010, RS moves.
//  6. rst=0 asserted while in FAULT with MSPWrite=1 -> full reset values, RUN state,
//     no pointer motion.

Source files
------------

// File: rtl/jala_pkg.sv
// Shared constants and types for the JALA stack-pointer unit.
package jala_pkg;

   localparam int unsigned WORD_BYTES = 2;
   localparam int unsigned FAULT_W    = 3;

   // Bit 0 overflow, bit 1 underflow, bit 2 selects RS.
   localparam logic [FAULT_W-1:0] FAULT_NONE   = 3'b000;
   localparam logic [FAULT_W-1:0] FAULT_MS_OVF = 3'b001;
   localparam logic [FAULT_W-1:0] FAULT_MS_UDF = 3'b010;
   localparam logic [FAULT_W-1:0] FAULT_RS_OVF = 3'b101;
   localparam logic [FAULT_W-1:0] FAULT_RS_UDF = 3'b110;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } sp_state_t;

endpackage

// File: rtl/stack_pointer_unit_if.sv
// Strobe inputs from the control FSM and stack-address/status outputs of the SP unit.
interface stack_pointer_unit_if #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned MS_DEPTH = 64,
   parameter int unsigned RS_DEPTH = 32
);
   import jala_pkg::*;

   localparam int unsigned MS_DW = $clog2(MS_DEPTH + 1);
   localparam int unsigned RS_DW = $clog2(RS_DEPTH + 1);

   logic               MSPop;
   logic               MSPWrite;
   logic               RSPop;
   logic               RSPWrite;
   logic               err_clr;
   logic [ADDR_W-1:0]  ms_top;
   logic [ADDR_W-1:0]  ms_second;
   logic [ADDR_W-1:0]  rs_top;
   logic [MS_DW-1:0]   ms_depth;
   logic [RS_DW-1:0]   rs_depth;
   logic               ms_empty;
   logic               ms_full;
   logic               rs_empty;
   logic               rs_full;
   logic               fault;
   logic [FAULT_W-1:0] fault_code;

   modport master (
      output MSPop, MSPWrite, RSPop, RSPWrite, err_clr,
      input  ms_top, ms_second, rs_top, ms_depth, rs_depth,
      input  ms_empty, ms_full, rs_empty, rs_full, fault, fault_code
   );

   modport slave (
      input  MSPop, MSPWrite, RSPop, RSPWrite, err_clr,
      output ms_top, ms_second, rs_top, ms_depth, rs_depth,
      output ms_empty, ms_full, rs_empty, rs_full, fault, fault_code
   );
endinterface

// File: rtl/stack_ptr_core.sv
// One downward-growing stack pointer with occupancy count, full/empty and
// same-cycle overflow/underflow detection; frozen while i_hold is high.
module stack_ptr_core #(
   parameter int unsigned ADDR_W     = 16,
   parameter logic [ADDR_W-1:0] BASE = '1,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned WORD_BYTES = 2,
   localparam int unsigned DEPTH_W   = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_wr,
   input  logic               i_pop,
   input  logic               i_hold,
   output logic [ADDR_W-1:0]  o_sp,
   output logic [DEPTH_W-1:0] o_depth,
   output logic               o_empty,
   output logic               o_full,
   output logic               o_ovf_c,
   output logic               o_udf_c
);

   logic [ADDR_W-1:0]  r_sp;
   logic [DEPTH_W-1:0] r_depth;
   logic               w_push;
   logic               w_pop;
   logic               w_empty;
   logic               w_full;

   assign w_push  = i_wr & ~i_pop & ~i_hold;
   assign w_pop   = i_wr &  i_pop & ~i_hold;
   assign w_empty = (r_depth == '0);
   assign w_full  = (r_depth == DEPTH_W'(DEPTH));
   assign o_ovf_c = w_push & w_full;
   assign o_udf_c = w_pop  & w_empty;

   // A faulting request leaves the pointer untouched.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sp    <= BASE;
         r_depth <= '0;
      end else if (w_push && !w_full) begin
         r_sp    <= r_sp - ADDR_W'(WORD_BYTES);
         r_depth <= r_depth + DEPTH_W'(1);
      end else if (w_pop && !w_empty) begin
         r_sp    <= r_sp + ADDR_W'(WORD_BYTES);
         r_depth <= r_depth - DEPTH_W'(1);
      end
   end

   assign o_sp    = r_sp;
   assign o_depth = r_depth;
   assign o_empty = w_empty;
   assign o_full  = w_full;

endmodule

// File: rtl/stack_pointer_unit.sv
// Main/return stack pointers of the JALA CPU with a sticky FAULT state on
// overflow/underflow; MS faults take priority when both stacks fault together.
module stack_pointer_unit
   import jala_pkg::*;
#(
   parameter int unsigned ADDR_W        = 16,
   parameter int unsigned WORD_BYTES    = jala_pkg::WORD_BYTES,
   parameter logic [ADDR_W-1:0] MS_BASE = 16'hFFFE,
   parameter int unsigned MS_DEPTH      = 64,
   parameter logic [ADDR_W-1:0] RS_BASE = 16'hFEFE,
   parameter int unsigned RS_DEPTH      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   stack_pointer_unit_if.slave  if_sp
);

   localparam int unsigned MS_DW = $clog2(MS_DEPTH + 1);
   localparam int unsigned RS_DW = $clog2(RS_DEPTH + 1);

   sp_state_t          r_state;
   sp_state_t          w_state_nxt;
   logic [FAULT_W-1:0] r_fault_code;
   logic [FAULT_W-1:0] w_fault_code_nxt;
   logic               w_hold;
   logic               w_ms_ovf;
   logic               w_ms_udf;
   logic               w_rs_ovf;
   logic               w_rs_udf;
   logic [ADDR_W-1:0]  w_ms_sp;
   logic [ADDR_W-1:0]  w_rs_sp;
   logic [MS_DW-1:0]   w_ms_depth;
   logic [RS_DW-1:0]   w_rs_depth;

   assign w_hold = (r_state == FAULT);

   stack_ptr_core #(
      .ADDR_W     (ADDR_W),
      .BASE       (MS_BASE),
      .DEPTH      (MS_DEPTH),
      .WORD_BYTES (WORD_BYTES)
   ) u_ms (
      .clk     (clk),
      .rst     (rst),
      .i_wr    (if_sp.MSPWrite),
      .i_pop   (if_sp.MSPop),
      .i_hold  (w_hold),
      .o_sp    (w_ms_sp),
      .o_depth (w_ms_depth),
      .o_empty (if_sp.ms_empty),
      .o_full  (if_sp.ms_full),
      .o_ovf_c (w_ms_ovf),
      .o_udf_c (w_ms_udf)
   );

   stack_ptr_core #(
      .ADDR_W     (ADDR_W),
      .BASE       (RS_BASE),
      .DEPTH      (RS_DEPTH),
      .WORD_BYTES (WORD_BYTES)
   ) u_rs (
      .clk     (clk),
      .rst     (rst),
      .i_wr    (if_sp.RSPWrite),
      .i_pop   (if_sp.RSPop),
      .i_hold  (w_hold),
      .o_sp    (w_rs_sp),
      .o_depth (w_rs_depth),
      .o_empty (if_sp.rs_empty),
      .o_full  (if_sp.rs_full),
      .o_ovf_c (w_rs_ovf),
      .o_udf_c (w_rs_udf)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= RUN;
         r_fault_code <= FAULT_NONE;
      end else begin
         r_state      <= w_state_nxt;
         r_fault_code <= w_fault_code_nxt;
      end
   end

   // Next state and latched fault code; strobes in FAULT are already masked by w_hold.
   always_comb begin
      w_state_nxt      = r_state;
      w_fault_code_nxt = r_fault_code;
      case (r_state)
         RUN: begin
            if (w_ms_ovf || w_ms_udf) begin
               w_state_nxt      = FAULT;
               w_fault_code_nxt = w_ms_ovf ? FAULT_MS_OVF : FAULT_MS_UDF;
            end else if (w_rs_ovf || w_rs_udf) begin
               w_state_nxt      = FAULT;
               w_fault_code_nxt = w_rs_ovf ? FAULT_RS_OVF : FAULT_RS_UDF;
            end
         end
         FAULT: begin
            if (if_sp.err_clr) begin
               w_state_nxt      = RUN;
               w_fault_code_nxt = FAULT_NONE;
            end
         end
         default: begin
            w_state_nxt      = RUN;
            w_fault_code_nxt = FAULT_NONE;
         end
      endcase
   end

   assign if_sp.ms_top     = w_ms_sp;
   assign if_sp.ms_second  = w_ms_sp + ADDR_W'(WORD_BYTES);
   assign if_sp.rs_top     = w_rs_sp;
   assign if_sp.ms_depth   = w_ms_depth;
   assign if_sp.rs_depth   = w_rs_depth;
   assign if_sp.fault      = (r_state == FAULT);
   assign if_sp.fault_code = r_fault_code;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed plus random stimulus for stack_pointer_unit against a behavioural
// stack model; expected snapshots are queued per step and compared after each edge.
module tb_stack_pointer_unit;

   typedef struct packed {
      logic [15:0] ms_top;
      logic [15:0] ms_second;
      logic [15:0] rs_top;
      logic [6:0]  ms_depth;
      logic [5:0]  rs_depth;
      logic        ms_empty;
      logic        ms_full;
      logic        rs_empty;
      logic        rs_full;
      logic        fault;
      logic [2:0]  code;
   } snap_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   snap_t exp_q[$];

   // Reference model state
   int   m_ms_d;
   int   m_rs_d;
   bit   m_fault;
   logic [2:0] m_code;

   stack_pointer_unit_if u_if ();

   stack_pointer_unit u_dut (
      .clk   (clk),
      .rst   (rst),
      .if_sp (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic snap_t model_snap();
      snap_t s;
      logic [15:0] ms_sp;
      logic [15:0] rs_sp;
      ms_sp = 16'(32'hFFFE - 2 * m_ms_d);
      rs_sp = 16'(32'hFEFE - 2 * m_rs_d);
      s.ms_top    = ms_sp;
      s.ms_second = 16'(ms_sp + 16'd2);
      s.rs_top    = rs_sp;
      s.ms_depth  = 7'(m_ms_d);
      s.rs_depth  = 6'(m_rs_d);
      s.ms_empty  = (m_ms_d == 0);
      s.ms_full   = (m_ms_d == 64);
      s.rs_empty  = (m_rs_d == 0);
      s.rs_full   = (m_rs_d == 32);
      s.fault     = m_fault;
      s.code      = m_code;
      return s;
   endfunction

   function automatic snap_t dut_snap();
      snap_t s;
      s.ms_top    = u_if.ms_top;
      s.ms_second = u_if.ms_second;
      s.rs_top    = u_if.rs_top;
      s.ms_depth  = u_if.ms_depth;
      s.rs_depth  = u_if.rs_depth;
      s.ms_empty  = u_if.ms_empty;
      s.ms_full   = u_if.ms_full;
      s.rs_empty  = u_if.rs_empty;
      s.rs_full   = u_if.rs_full;
      s.fault     = u_if.fault;
      s.code      = u_if.fault_code;
      return s;
   endfunction

   task automatic model_edge(input bit r, input bit mw, input bit mp,
                             input bit rw, input bit rp, input bit clr);
      bit ms_f;
      bit rs_f;
      if (!r) begin
         m_ms_d = 0; m_rs_d = 0; m_fault = 0; m_code = 3'b000;
      end else if (m_fault) begin
         if (clr) begin m_fault = 0; m_code = 3'b000; end
      end else begin
         ms_f = mw && (mp ? (m_ms_d == 0) : (m_ms_d == 64));
         rs_f = rw && (rp ? (m_rs_d == 0) : (m_rs_d == 32));
         if (mw && !ms_f) m_ms_d = mp ? m_ms_d - 1 : m_ms_d + 1;
         if (rw && !rs_f) m_rs_d = rp ? m_rs_d - 1 : m_rs_d + 1;
         if (ms_f) begin
            m_fault = 1; m_code = mp ? 3'b010 : 3'b001;
         end else if (rs_f) begin
            m_fault = 1; m_code = rp ? 3'b110 : 3'b101;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One clock: drive on the falling edge, queue the expectation, compare after the rising edge.
   task automatic step(input bit r, input bit mw, input bit mp,
                       input bit rw, input bit rp, input bit clr);
      snap_t e;
      snap_t o;
      @(negedge clk);
      rst = r;
      u_if.MSPWrite = mw; u_if.MSPop = mp;
      u_if.RSPWrite = rw; u_if.RSPop = rp;
      u_if.err_clr  = clr;
      model_edge(r, mw, mp, rw, rp, clr);
      exp_q.push_back(model_snap());
      @(posedge clk);
      #1;
      o = dut_snap();
      e = exp_q.pop_front();
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL snapshot observed=%h expected=%h", o, e);
      end
      u_if.MSPWrite = 1'b0; u_if.RSPWrite = 1'b0; u_if.err_clr = 1'b0;
      rst = 1'b1;
   endtask

   initial begin
      checks = 0; failures = 0;
      m_ms_d = 0; m_rs_d = 0; m_fault = 0; m_code = 3'b000;
      rst = 1'b0;
      u_if.MSPWrite = 1'b0; u_if.MSPop = 1'b0;
      u_if.RSPWrite = 1'b0; u_if.RSPop = 1'b0;
      u_if.err_clr  = 1'b0;

      // Reset values
      step(0, 0, 0, 0, 0, 0);
      chk("rst_ms_top", 32'(u_if.ms_top), 32'hFFFE);
      chk("rst_rs_top", 32'(u_if.rs_top), 32'hFEFE);
      chk("rst_ms_depth", 32'(u_if.ms_depth), 32'd0);
      chk("rst_empty", {30'd0, u_if.ms_empty, u_if.rs_empty}, 32'd3);
      chk("rst_fault", 32'(u_if.fault), 32'd0);

      // Three pushes then a pop
      repeat (3) step(1, 1, 0, 0, 0, 0);
      chk("push3_ms_top", 32'(u_if.ms_top), 32'hFFF8);
      step(1, 1, 1, 0, 0, 0);
      chk("pop_ms_top", 32'(u_if.ms_top), 32'hFFFA);
      chk("pop_ms_second", 32'(u_if.ms_second), 32'hFFFC);
      chk("pop_ms_depth", 32'(u_if.ms_depth), 32'd2);

      // RS underflow, frozen stacks, clear
      step(1, 0, 0, 1, 1, 0);
      chk("rs_udf_fault", 32'(u_if.fault), 32'd1);
      chk("rs_udf_code", 32'(u_if.fault_code), 32'b110);
      chk("rs_udf_top", 32'(u_if.rs_top), 32'hFEFE);
      step(1, 1, 0, 0, 0, 0);
      chk("frozen_ms_top", 32'(u_if.ms_top), 32'hFFFA);
      step(1, 1, 0, 1, 0, 1);
      chk("clr_fault", 32'(u_if.fault), 32'd0);
      chk("clr_code", 32'(u_if.fault_code), 32'b000);
      chk("clr_drops_strobe", 32'(u_if.ms_top), 32'hFFFA);
      step(1, 0, 0, 0, 0, 1);
      chk("clr_in_run", 32'(u_if.fault), 32'd0);

      // Fill MS, then overflow
      step(0, 0, 0, 0, 0, 0);
      repeat (64) step(1, 1, 0, 0, 0, 0);
      chk("full_flag", 32'(u_if.ms_full), 32'd1);
      chk("full_ms_top", 32'(u_if.ms_top), 32'hFF7E);
      step(1, 1, 0, 0, 0, 0);
      chk("ovf_code", 32'(u_if.fault_code), 32'b001);
      chk("ovf_depth", 32'(u_if.ms_depth), 32'd64);
      step(1, 0, 0, 0, 0, 1);

      // Same-edge updates and faults
      step(0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 1, 0, 0);
      chk("dual_ms_top", 32'(u_if.ms_top), 32'hFFFC);
      chk("dual_rs_top", 32'(u_if.rs_top), 32'hFEFC);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 1, 0, 0);
      chk("ms_udf_rs_push_code", 32'(u_if.fault_code), 32'b010);
      chk("ms_udf_rs_push_rs", 32'(u_if.rs_top), 32'hFEFA);

      // Reset during FAULT with a strobe
      step(0, 1, 0, 0, 0, 0);
      chk("rst_fault_ms_top", 32'(u_if.ms_top), 32'hFFFE);
      chk("rst_fault_state", {29'd0, u_if.fault, u_if.fault_code}, 32'd0);
      chk("rst_fault_rs_top", 32'(u_if.rs_top), 32'hFEFE);

      // Both stacks fault together: MS recorded
      step(1, 1, 1, 1, 1, 0);
      chk("dual_fault_code", 32'(u_if.fault_code), 32'b010);
      step(1, 0, 0, 0, 0, 1);

      // Fill RS to full and overflow it
      repeat (33) step(1, 0, 0, 1, 0, 0);
      chk("rs_ovf_code", 32'(u_if.fault_code), 32'b101);
      chk("rs_full_flag", 32'(u_if.rs_full), 32'd1);
      step(1, 0, 0, 0, 0, 1);

      // Random traffic biased toward pushes and clears
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 199) != 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
